// File: rtl/fetch_stage_if.sv
// +--------------------------------------------------------------------+
// | fetch_stage_if : handshake/bus bundle between fetch and pipeline   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   StallF_i;
  logic                   StallD_i;
  logic                   FlushD_i;
  logic [INSTR_WIDTH-1:0] InstrF_i;
  logic                   ResolveE_i;
  logic                   ActualTakenE_i;
  logic                   PredTakenE_i;
  logic [PC_WIDTH-1:0]    PCE_i;
  logic [PC_WIDTH-1:0]    PCTargetE_i;
  logic [PC_WIDTH-1:0]    PCPlus4E_i;

  logic [PC_WIDTH-1:0]    PCF_o;
  logic [INSTR_WIDTH-1:0] InstrD_o;
  logic [PC_WIDTH-1:0]    PCD_o;
  logic [PC_WIDTH-1:0]    PCPlus4D_o;
  logic                   PredTakenD_o;
  logic                   MispredictE_o;

  modport master (
    output StallF_i, StallD_i, FlushD_i, InstrF_i,
    output ResolveE_i, ActualTakenE_i, PredTakenE_i,
    output PCE_i, PCTargetE_i, PCPlus4E_i,
    input  PCF_o, InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o, MispredictE_o
  );

  modport slave (
    input  StallF_i, StallD_i, FlushD_i, InstrF_i,
    input  ResolveE_i, ActualTakenE_i, PredTakenE_i,
    input  PCE_i, PCTargetE_i, PCPlus4E_i,
    output PCF_o, InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o, MispredictE_o
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------+
// | fetch_stage : PC register, optional BHT/BTB predictor, F/D register |
// | Predictor enabled by defining FETCH_BRANCH_PREDICT_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_stage #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  BHT_ENTRIES = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.slave  bus
);

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

  logic [PC_WIDTH-1:0]    pcf_q;
  logic [PC_WIDTH-1:0]    pc_plus4_f;
  logic [PC_WIDTH-1:0]    pc_next;
  logic                   pred_taken_f;
  logic [PC_WIDTH-1:0]    pred_target_f;
  logic                   mispredict;
  logic [INSTR_WIDTH-1:0] instr_d_q;
  logic [PC_WIDTH-1:0]    pc_d_q;
  logic [PC_WIDTH-1:0]    pc_plus4_d_q;
  logic                   pred_d_q;
  logic                   unused_pce_bits;

  assign pc_plus4_f = pcf_q + PC_WIDTH'(4);
  assign mispredict = bus.ResolveE_i & (bus.ActualTakenE_i != bus.PredTakenE_i);

`ifdef FETCH_BRANCH_PREDICT_EN
  localparam int IDX   = $clog2(BHT_ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  logic [BHT_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BHT_ENTRIES];
  logic [PC_WIDTH-1:0]    target_q [BHT_ENTRIES];
  logic [1:0]             ctr_q    [BHT_ENTRIES];

  logic [IDX-1:0]   lk_idx;
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = pcf_q[IDX+1:2];
  assign up_idx = bus.PCE_i[IDX+1:2];
  assign up_tag = bus.PCE_i[PC_WIDTH-1:IDX+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Read the arrays before this edge's update lands, so a same-cycle
  // lookup of the entry being trained sees its old contents.
  assign pred_taken_f  = valid_q[lk_idx] && (tag_q[lk_idx] == pcf_q[PC_WIDTH-1:IDX+2])
                         && ctr_q[lk_idx][1];
  assign pred_target_f = target_q[lk_idx];
  assign unused_pce_bits = ^bus.PCE_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (bus.ResolveE_i) begin
      if (up_hit) begin
        if (bus.ActualTakenE_i) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= bus.PCTargetE_i;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.ActualTakenE_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.PCTargetE_i;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end
`else
  assign pred_taken_f    = 1'b0;
  assign pred_target_f   = pc_plus4_f;
  assign unused_pce_bits = ^bus.PCE_i;
`endif

  always_comb begin
    pc_next = pc_plus4_f;
    if (mispredict)        pc_next = bus.ActualTakenE_i ? bus.PCTargetE_i : bus.PCPlus4E_i;
    else if (bus.StallF_i) pc_next = pcf_q;
    else if (pred_taken_f) pc_next = pred_target_f;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pcf_q <= RESET_PC;
    else       pcf_q <= pc_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.FlushD_i || mispredict) begin
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      pred_d_q     <= 1'b0;
    end else if (!bus.StallD_i) begin
      instr_d_q    <= bus.InstrF_i;
      pc_d_q       <= pcf_q;
      pc_plus4_d_q <= pc_plus4_f;
      pred_d_q     <= pred_taken_f;
    end
  end

  assign bus.PCF_o         = pcf_q;
  assign bus.InstrD_o      = instr_d_q;
  assign bus.PCD_o         = pc_d_q;
  assign bus.PCPlus4D_o    = pc_plus4_d_q;
  assign bus.PredTakenD_o  = pred_d_q;
  assign bus.MispredictE_o = mispredict;

endmodule

`default_nettype wire
